multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 218 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle control FSM for an ARM subset: LDR 5, STR/data-processing 4, B 3, Op=11 2 cycles.
// No backpressure; outputs decode from state and Instr. `BRANCH_LINK_EN adds BL link write in BRANCH.
module multicycle_controller #(
   parameter int ALUCTRL_W = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [19:0]          Instr,
   input  logic [3:0]           ALUFlags,
   output logic                 PCWrite,
   output logic                 AdrSrc,
   output logic                 MemWrite,
   output logic                 IRWrite,
   output logic                 ALUSrcA,
   output logic                 RegWrite,
   output logic [1:0]           ResultSrc,
   output logic [1:0]           ALUSrcB,
   output logic [1:0]           ImmSrc,
   output logic [1:0]           RegSrc,
   output logic [ALUCTRL_W-1:0] ALUControl,
   output logic                 LinkSel,
   output logic                 Busy
);

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
   } state_t;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_ORR = 3'd3;
   localparam logic [2:0] OP_EOR = 3'd4;

   state_t     state_q, state_d;
   logic [3:0] flags_q, flags_d;

   logic [3:0] cond;
   logic [1:0] op;
   logic [5:0] funct;
   logic       rd15;
   logic       cond_ex;
   logic [2:0] alu_dec;
   logic       no_write, undef, arith;
   logic       link_req;

   logic       pc_write, adr_src, mem_write, ir_write, alu_src_a, reg_write, link_sel;
   logic [1:0] result_src, alu_src_b;
   logic [2:0] alu_sel;
   logic       unused_bits;

   assign cond  = Instr[19:16];
   assign op    = Instr[15:14];
   assign funct = Instr[13:8];
   assign rd15  = (Instr[3:0] == 4'hF);

   // Rn is routed by the datapath; bit 2 of the ALU select is dropped when ALUCTRL_W is 2
   assign unused_bits = ^{Instr[7:4], alu_sel};

`ifdef BRANCH_LINK_EN
   assign link_req = funct[4];
`else
   assign link_req = 1'b0;
`endif

   always_comb begin
      cond_ex = 1'b0;
      case (cond)
         4'b0000: cond_ex = flags_q[2];
         4'b0001: cond_ex = ~flags_q[2];
         4'b0010: cond_ex = flags_q[1];
         4'b0011: cond_ex = ~flags_q[1];
         4'b0100: cond_ex = flags_q[3];
         4'b0101: cond_ex = ~flags_q[3];
         4'b0110: cond_ex = flags_q[0];
         4'b0111: cond_ex = ~flags_q[0];
         4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
         4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
         4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
         4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
         4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
         4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   always_comb begin
      alu_dec  = OP_ADD;
      no_write = 1'b0;
      undef    = 1'b0;
      arith    = 1'b0;
      case (funct[4:1])
         4'b0100: begin alu_dec = OP_ADD; arith = 1'b1; end
         4'b0010: begin alu_dec = OP_SUB; arith = 1'b1; end
         4'b0000: alu_dec = OP_AND;
         4'b1100: alu_dec = OP_ORR;
         4'b1010: begin alu_dec = OP_SUB; arith = 1'b1; no_write = 1'b1; end
         4'b0001: begin
            if (ALUCTRL_W == 3) alu_dec = OP_EOR;
            else                undef   = 1'b1;
         end
         default: undef = 1'b1;
      endcase
   end

   // Flags latch only for a condition-passing, S-bit, defined ALU operation
   always_comb begin
      flags_d = flags_q;
      if ((state_q == EXECR || state_q == EXECI) && cond_ex && funct[0] && !undef) begin
         flags_d[3:2] = ALUFlags[3:2];
         if (arith) flags_d[1:0] = ALUFlags[1:0];
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      alu_src_a  = 1'b0;
      reg_write  = 1'b0;
      link_sel   = 1'b0;
      result_src = 2'b00;
      alu_src_b  = 2'b00;
      alu_sel    = OP_ADD;
      case (state_q)
         FETCH: begin
            ir_write   = 1'b1;
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            pc_write   = 1'b1;
            state_d    = DECODE;
         end
         DECODE: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            case (op)
               2'b01:   state_d = MEMADR;
               2'b00:   state_d = funct[5] ? EXECI : EXECR;
               2'b10:   state_d = BRANCH;
               default: state_d = FETCH;
            endcase
         end
         MEMADR: begin
            alu_src_b = 2'b01;
            state_d   = funct[0] ? MEMRD : MEMWR;
         end
         MEMRD: begin
            adr_src = 1'b1;
            state_d = MEMWB;
         end
         MEMWB: begin
            result_src = 2'b01;
            reg_write  = cond_ex;
            pc_write   = cond_ex & rd15;
            state_d    = FETCH;
         end
         MEMWR: begin
            adr_src   = 1'b1;
            mem_write = cond_ex;
            state_d   = FETCH;
         end
         EXECR: begin
            alu_sel = alu_dec;
            state_d = ALUWB;
         end
         EXECI: begin
            alu_src_b = 2'b01;
            alu_sel   = alu_dec;
            state_d   = ALUWB;
         end
         ALUWB: begin
            reg_write = cond_ex & ~no_write & ~undef;
            pc_write  = cond_ex & ~no_write & ~undef & rd15;
            state_d   = FETCH;
         end
         BRANCH: begin
            alu_src_b  = 2'b01;
            result_src = 2'b10;
            pc_write   = cond_ex;
            link_sel   = link_req;
            reg_write  = cond_ex & link_req;
            state_d    = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= FETCH;
         flags_q <= 4'b0000;
      end else begin
         state_q <= state_d;
         flags_q <= flags_d;
      end
   end

   // Outputs are gated by reset so they drop without waiting for a clock edge
   assign PCWrite    = pc_write  & ~reset;
   assign AdrSrc     = adr_src   & ~reset;
   assign MemWrite   = mem_write & ~reset;
   assign IRWrite    = ir_write  & ~reset;
   assign ALUSrcA    = alu_src_a & ~reset;
   assign RegWrite   = reg_write & ~reset;
   assign LinkSel    = link_sel  & ~reset;
   assign ResultSrc  = reset ? 2'b00 : result_src;
   assign ALUSrcB    = reset ? 2'b00 : alu_src_b;
   assign ALUControl = reset ? '0 : alu_sel[ALUCTRL_W-1:0];
   assign ImmSrc     = (reset || state_q == FETCH) ? 2'b00 : op;
   assign RegSrc     = (reset || state_q == FETCH) ? 2'b00 : {op == 2'b01, op == 2'b10};
   assign Busy       = (state_q != FETCH);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller; a second instance with ALUCTRL_W=3 covers EOR.
`timescale 1ns/1ps
module tb_multicycle_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [19:0] Instr;
   logic [3:0]  ALUFlags;

   logic       pcw_a, adr_a, mw_a, irw_a, asa_a, rw_a, link_a, busy_a;
   logic [1:0] rs_a, asb_a, imm_a, rsrc_a, aluc_a;
   logic       pcw_b, adr_b, mw_b, irw_b, asa_b, rw_b, link_b, busy_b;
   logic [1:0] rs_b, asb_b, imm_b, rsrc_b;
   logic [2:0] aluc_b;
   logic [17:0] ctl_a;

   int checks = 0;
   int errors = 0;
   logic [17:0] exp_q[$];

`ifdef BRANCH_LINK_EN
   localparam logic LINK = 1'b1;
`else
   localparam logic LINK = 1'b0;
`endif

   always #5 clk = ~clk;

   multicycle_controller #(.ALUCTRL_W(2)) dut_w2 (
      .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
      .PCWrite(pcw_a), .AdrSrc(adr_a), .MemWrite(mw_a), .IRWrite(irw_a),
      .ALUSrcA(asa_a), .RegWrite(rw_a), .ResultSrc(rs_a), .ALUSrcB(asb_a),
      .ImmSrc(imm_a), .RegSrc(rsrc_a), .ALUControl(aluc_a), .LinkSel(link_a), .Busy(busy_a)
   );

   multicycle_controller #(.ALUCTRL_W(3)) dut_w3 (
      .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
      .PCWrite(pcw_b), .AdrSrc(adr_b), .MemWrite(mw_b), .IRWrite(irw_b),
      .ALUSrcA(asa_b), .RegWrite(rw_b), .ResultSrc(rs_b), .ALUSrcB(asb_b),
      .ImmSrc(imm_b), .RegSrc(rsrc_b), .ALUControl(aluc_b), .LinkSel(link_b), .Busy(busy_b)
   );

   assign ctl_a = {pcw_a, adr_a, mw_a, irw_a, asa_a, rw_a, rs_a, asb_a, imm_a, rsrc_a, aluc_a, link_a, busy_a};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [19:0] mk(input logic [3:0] c, input logic [1:0] o,
                                      input logic [5:0] f, input logic [3:0] rd);
      return {c, o, f, 4'h0, rd};
   endfunction

   function automatic logic [17:0] ev(input logic pcw, adr, mw, irw, asa, rw,
                                      input logic [1:0] rs, asb, imm, rsrc, aluc,
                                      input logic link, busy);
      return {pcw, adr, mw, irw, asa, rw, rs, asb, imm, rsrc, aluc, link, busy};
   endfunction

   function automatic logic [17:0] e_f();
      return ev(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
   endfunction

   function automatic logic [17:0] e_d(input logic [1:0] imm, input logic [1:0] rsrc);
      return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b10, imm, rsrc, 2'b00, 1'b0, 1'b1);
   endfunction

   function automatic logic [17:0] e_ex(input logic [1:0] asb, input logic [1:0] aluc);
      return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, asb, 2'b00, 2'b00, aluc, 1'b0, 1'b1);
   endfunction

   function automatic logic [17:0] e_wb(input logic rw);
      return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rw, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
   endfunction

   function automatic logic [17:0] e_br(input logic pcw, input logic rw, input logic link);
      return ev(pcw, 1'b0, 1'b0, 1'b0, 1'b0, rw, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00, link, 1'b1);
   endfunction

   // Memory-instruction states (Op=01: ImmSrc=01, RegSrc=10)
   function automatic logic [17:0] e_madr();
      return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00, 1'b0, 1'b1);
   endfunction

   // Holds one instruction for as many cycles as expectations are queued, one check per cycle
   task automatic play(input string tag, input logic [19:0] ins, input logic [3:0] fl);
      int n;
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         Instr    = ins;
         ALUFlags = fl;
         #1;
         chk($sformatf("%s.%0d", tag, i), 32'(ctl_a), 32'(exp_q[i]));
         @(negedge clk);
      end
      exp_q.delete();
   endtask

   task automatic dp(input string tag, input logic [5:0] f, input logic [3:0] fl,
                     input logic [1:0] asb, input logic [1:0] aluc, input logic rw);
      exp_q.push_back(e_f());
      exp_q.push_back(e_d(2'b00, 2'b00));
      exp_q.push_back(e_ex(asb, aluc));
      exp_q.push_back(e_wb(rw));
      play(tag, mk(4'hE, 2'b00, f, 4'd1), fl);
   endtask

   task automatic br(input string tag, input logic [3:0] c, input logic [5:0] f,
                     input logic pcw, input logic rw, input logic link);
      exp_q.push_back(e_f());
      exp_q.push_back(e_d(2'b10, 2'b01));
      exp_q.push_back(e_br(pcw, rw, link));
      play(tag, mk(c, 2'b10, f, 4'd0), 4'b0000);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1);
   end

   initial begin
      reset    = 1'b1;
      Instr    = 20'h0;
      ALUFlags = 4'b0000;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_idle", 32'(ctl_a), 32'd0);
      reset = 1'b0;

      dp("add_r1",  6'b001000, 4'b0000, 2'b00, 2'b00, 1'b1);
      dp("subi_r1", 6'b100100, 4'b0000, 2'b01, 2'b01, 1'b1);

      // CMP sets Z, BEQ taken; then Z clear, BEQ not taken, BNE taken
      dp("cmp_z1", 6'b010101, 4'b0100, 2'b00, 2'b01, 1'b0);
      br("beq_tk", 4'b0000, 6'b000000, 1'b1, 1'b0, 1'b0);
      dp("cmp_z0", 6'b010101, 4'b0000, 2'b00, 2'b01, 1'b0);
      br("beq_nt", 4'b0000, 6'b000000, 1'b0, 1'b0, 1'b0);
      br("bne_tk", 4'b0001, 6'b000000, 1'b1, 1'b0, 1'b0);

      // ANDS must leave C from the preceding CMP alone
      dp("cmp_c1", 6'b010101, 4'b0010, 2'b00, 2'b01, 1'b0);
      dp("ands",   6'b000001, 4'b0100, 2'b00, 2'b10, 1'b1);
      br("bcs_tk", 4'b0010, 6'b000000, 1'b1, 1'b0, 1'b0);
      br("beq_and", 4'b0000, 6'b000000, 1'b1, 1'b0, 1'b0);
      br("bnv",    4'b1111, 6'b000000, 1'b0, 1'b0, 1'b0);

      exp_q.push_back(e_f());
      exp_q.push_back(e_d(2'b01, 2'b10));
      exp_q.push_back(e_madr());
      exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b1));
      exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b1));
      play("ldr_pc", mk(4'hE, 2'b01, 6'b011001, 4'hF), 4'b0000);

      exp_q.push_back(e_f());
      exp_q.push_back(e_d(2'b01, 2'b10));
      exp_q.push_back(e_madr());
      exp_q.push_back(ev(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b1));
      play("str", mk(4'hE, 2'b01, 6'b011000, 4'd2), 4'b0000);

      exp_q.push_back(e_f());
      exp_q.push_back(e_d(2'b11, 2'b00));
      play("op11", mk(4'hE, 2'b11, 6'b000000, 4'd0), 4'b0000);

      // EOR: defined only for the 3-bit ALUControl instance
      Instr    = mk(4'hE, 2'b00, 6'b000010, 4'd3);
      ALUFlags = 4'b0000;
      repeat (2) @(negedge clk);
      #1;
      chk("eor_w3_aluc", 32'(aluc_b), 32'd4);
      @(negedge clk);
      #1;
      chk("eor_w3_rw", 32'(rw_b), 32'd1);
      chk("eor_w2_rw", 32'(rw_a), 32'd0);
      @(negedge clk);

      br("bl", 4'hE, 6'b010000, 1'b1, LINK, LINK);

      // Reset in MEMRD with Z=1 held: outputs drop at once, flags clear
      dp("cmp_pre", 6'b010101, 4'b0100, 2'b00, 2'b01, 1'b0);
      exp_q.push_back(e_f());
      exp_q.push_back(e_d(2'b01, 2'b10));
      exp_q.push_back(e_madr());
      play("ldr_rst", mk(4'hE, 2'b01, 6'b011001, 4'd4), 4'b0000);
      #1;
      chk("memrd_adr", 32'(adr_a), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_async", 32'(ctl_a), 32'd0);
      @(negedge clk);
      #1;
      chk("rst_hold", 32'(ctl_a), 32'd0);
      reset = 1'b0;
      br("beq_rst", 4'b0000, 6'b000000, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
